// File: rtl/tdc_burst_averager.sv
// tdc_burst_averager: runs 2^LOG2_N TDC conversions and reports the truncated mean via valid/ack.
// Define TDC_BURST_MINMAX_EN to add per-burst min_out/max_out.
module tdc_burst_averager #(
  parameter int WIDTH     = 8,
  parameter int LOG2_N    = 2,
  parameter int START_LEN = 5,
  parameter int TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] count_in,
  input  logic             tdc_ready,
  output logic             tdc_start,
  output logic             busy,
  output logic [WIDTH-1:0] avg_out,
  output logic             avg_valid,
  input  logic             avg_ack,
  output logic             timeout_err
`ifdef TDC_BURST_MINMAX_EN
  ,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out
`endif
);
  localparam int ACC_W = WIDTH + LOG2_N;
  localparam logic [LOG2_N:0] LAST = (LOG2_N+1)'((1 << LOG2_N) - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_ACCUM, S_DONE, S_ERR} state_t;
  state_t state_q;
  logic ready_q, tdc_start_q, busy_q, avg_valid_q, timeout_err_q, ready_rise, go;
  logic [WIDTH-1:0] cap_q, avg_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LOG2_N:0] cnt_q;
  logic [3:0] slen_q;
  logic [15:0] tmo_q;
  assign ready_rise = tdc_ready & ~ready_q;
  assign acc_d = acc_q + ACC_W'(cap_q);
  assign go = enable & ((state_q == S_IDLE) | (state_q == S_ERR));
  assign tdc_start = tdc_start_q;
  assign busy = busy_q;
  assign avg_out = avg_q;
  assign avg_valid = avg_valid_q;
  assign timeout_err = timeout_err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ready_q       <= 1'b0;
      tdc_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      avg_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      cap_q         <= '0;
      avg_q         <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      slen_q        <= '0;
      tmo_q         <= '0;
    end else begin
      ready_q <= tdc_ready;
      case (state_q)
        S_IDLE, S_ERR: if (enable) begin
          state_q       <= S_START;
          acc_q         <= '0;
          cnt_q         <= '0;
          slen_q        <= '0;
          tdc_start_q   <= 1'b1;
          busy_q        <= 1'b1;
          timeout_err_q <= 1'b0;
        end
        S_START: if (slen_q == 4'(START_LEN-1)) begin
          state_q     <= S_WAIT;
          tdc_start_q <= 1'b0;
          tmo_q       <= '0;
        end else slen_q <= slen_q + 1'b1;
        S_WAIT: if (ready_rise) begin
          cap_q   <= count_in;
          state_q <= S_ACCUM;
        end else if (tmo_q == 16'(TIMEOUT-1)) begin
          state_q       <= S_ERR;
          timeout_err_q <= 1'b1;
          busy_q        <= 1'b0;
        end else tmo_q <= tmo_q + 1'b1;
        S_ACCUM: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q     <= S_DONE;
            avg_q       <= acc_d[ACC_W-1:LOG2_N];
            avg_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            state_q     <= S_START;
            slen_q      <= '0;
            tdc_start_q <= 1'b1;
          end
        end
        S_DONE: if (avg_ack) begin
          state_q     <= S_IDLE;
          avg_valid_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
`ifdef TDC_BURST_MINMAX_EN
  logic [WIDTH-1:0] mn_q, mx_q, mn_d, mx_d, min_q, max_q;
  assign mn_d = cap_q < mn_q ? cap_q : mn_q;
  assign mx_d = cap_q > mx_q ? cap_q : mx_q;
  assign min_out = min_q;
  assign max_out = max_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      mn_q  <= '0;
      mx_q  <= '0;
      min_q <= '0;
      max_q <= '0;
    end else if (go) begin
      mn_q <= '1;
      mx_q <= '0;
    end else if (state_q == S_ACCUM) begin
      mn_q <= mn_d;
      mx_q <= mx_d;
      if (cnt_q == LAST) begin
        min_q <= mn_d;
        max_q <= mx_d;
      end
    end
  end
`endif
endmodule

// File: tb/tb_tdc_burst_averager.sv
// tb_tdc_burst_averager: randomized bursts against a behavioural TDC and a mean/min/max reference.
module tb_tdc_burst_averager;
  localparam int WIDTH = 8, LOG2_N = 2, START_LEN = 5, TIMEOUT = 255, N = 1 << LOG2_N;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, tdc_ready = 1'b0, avg_ack = 1'b0;
  logic [WIDTH-1:0] count_in = '0;
  logic tdc_start, busy, avg_valid, timeout_err;
  logic [WIDTH-1:0] avg_out;
`ifdef TDC_BURST_MINMAX_EN
  logic [WIDTH-1:0] min_out, max_out;
`endif
  logic [WIDTH-1:0] smp [N];
  bit en_after, hold_ready;
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  tdc_burst_averager #(.WIDTH(WIDTH), .LOG2_N(LOG2_N), .START_LEN(START_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .count_in(count_in), .tdc_ready(tdc_ready),
    .tdc_start(tdc_start), .busy(busy), .avg_out(avg_out), .avg_valid(avg_valid),
    .avg_ack(avg_ack), .timeout_err(timeout_err)
`ifdef TDC_BURST_MINMAX_EN
    , .min_out(min_out), .max_out(max_out)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: still running at %0t, expected to have finished", $time);
    $fatal(1);
  end

  // One TDC conversion: wait for the start pulse, measure it, then answer (or hang).
  task automatic convert(input logic [WIDTH-1:0] c, input bit glitch, input bit hang);
    int t, plen, dly;
    t = 0;
    while (tdc_start !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    nvec++;
    if (tdc_start !== 1'b1) begin
      nerr++;
      $display("FAIL start_seen: tdc_start=%b after %0d cycles, expected 1", tdc_start, t);
      return;
    end
    plen = 0;
    while (tdc_start === 1'b1 && plen < 40) begin
      plen++;
      if (plen == 1) enable = en_after;
      if (glitch && plen == 1) tdc_ready = 1'b0;
      if (glitch && plen == 2) begin tdc_ready = 1'b1; count_in = 8'hEE; end
      if (glitch && plen == 3) tdc_ready = 1'b0;
      @(negedge clk);
    end
    nvec++;
    if (plen != START_LEN) begin nerr++; $display("FAIL start_len: got %0d cycles, expected %0d", plen, START_LEN); end
    nvec++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL busy_wait: got %b, expected 1", busy); end
    if (hang) return;
    dly = $urandom_range(0, 6);
    repeat (dly) @(negedge clk);
    count_in = c;
    tdc_ready = 1'b1;
    @(negedge clk);
    tdc_ready = hold_ready;
    count_in = WIDTH'($urandom);
  endtask

  task automatic run_burst(input string name, input int ack_dly, input bit keep_en, input bit glitch);
    int sum, mn, mx, bad;
    logic [WIDTH-1:0] exp_avg;
    sum = 0; mn = (1 << WIDTH) - 1; mx = 0; bad = 0;
    foreach (smp[i]) begin
      sum += int'(smp[i]);
      if (int'(smp[i]) < mn) mn = int'(smp[i]);
      if (int'(smp[i]) > mx) mx = int'(smp[i]);
    end
    exp_avg = WIDTH'(sum / N);
    enable = 1'b1; en_after = keep_en; hold_ready = glitch;
    for (int i = 0; i < N; i++) convert(smp[i], glitch, 1'b0);
    nvec++;
    if (avg_valid !== 1'b0) begin nerr++; $display("FAIL %s valid_early: got %b, expected 0", name, avg_valid); end
    @(negedge clk);
    nvec++;
    if (avg_valid !== 1'b1) begin nerr++; $display("FAIL %s valid_latency: got %b, expected 1", name, avg_valid); end
    nvec++;
    if (avg_out !== exp_avg) begin nerr++; $display("FAIL %s avg: got %0d, expected %0d", name, avg_out, exp_avg); end
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL %s busy_done: got %b, expected 0", name, busy); end
`ifdef TDC_BURST_MINMAX_EN
    nvec++;
    if (min_out !== WIDTH'(mn) || max_out !== WIDTH'(mx)) begin
      nerr++; $display("FAIL %s minmax: got %0d/%0d, expected %0d/%0d", name, min_out, max_out, mn, mx);
    end
`endif
    repeat (ack_dly) begin
      @(negedge clk);
      if (avg_valid !== 1'b1 || avg_out !== exp_avg || tdc_start !== 1'b0) bad++;
    end
    nvec++;
    if (bad != 0) begin nerr++; $display("FAIL %s hold: %0d unstable cycles, expected 0", name, bad); end
    avg_ack = 1'b1;
    @(negedge clk);
    avg_ack = 1'b0;
    nvec++;
    if (avg_valid !== 1'b0 || tdc_start !== 1'b0) begin
      nerr++; $display("FAIL %s ack: valid=%b start=%b, expected 0/0", name, avg_valid, tdc_start);
    end
    if (keep_en) begin
      @(negedge clk);
      nvec++;
      if (tdc_start !== 1'b1) begin nerr++; $display("FAIL %s restart: tdc_start=%b, expected 1", name, tdc_start); end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nvec++;
    if ({tdc_start, busy, avg_valid, timeout_err} !== 4'b0) begin
      nerr++; $display("FAIL reset_flags: got %b, expected 0000", {tdc_start, busy, avg_valid, timeout_err});
    end
    nvec++;
    if (avg_out !== '0) begin nerr++; $display("FAIL reset_avg: got %0d, expected 0", avg_out); end
    rst = 1'b0;
    avg_ack = 1'b1;
    @(negedge clk);
    avg_ack = 1'b0;
    @(negedge clk);
    nvec++;
    if ({busy, avg_valid, tdc_start} !== 3'b0) begin
      nerr++; $display("FAIL idle_ack: got %b, expected 000", {busy, avg_valid, tdc_start});
    end
  endtask

  task automatic test_basic;
    smp[0] = 3; smp[1] = 6; smp[2] = 3; smp[3] = 6;
    run_burst("basic", 4, 1'b0, 1'b0);
  endtask

  task automatic test_saturate;
    foreach (smp[i]) smp[i] = 8'd255;
    run_burst("saturate", 2, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    foreach (smp[i]) smp[i] = WIDTH'($urandom);
    run_burst("b2b_first", 20, 1'b1, 1'b0);
    foreach (smp[i]) smp[i] = WIDTH'($urandom);
    run_burst("b2b_second", 1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    int k;
    enable = 1'b1; en_after = 1'b0; hold_ready = 1'b0;
    convert(8'd10, 1'b0, 1'b0);
    convert(8'd20, 1'b0, 1'b1);
    k = 0;
    while (timeout_err !== 1'b1 && k < TIMEOUT + 20) begin @(negedge clk); k++; end
    nvec++;
    if (k != TIMEOUT) begin nerr++; $display("FAIL timeout_cycles: got %0d, expected %0d", k, TIMEOUT); end
    nvec++;
    if (avg_valid !== 1'b0 || busy !== 1'b0) begin
      nerr++; $display("FAIL timeout_outputs: valid=%b busy=%b, expected 0/0", avg_valid, busy);
    end
    repeat (3) @(negedge clk);
    nvec++;
    if (timeout_err !== 1'b1) begin nerr++; $display("FAIL timeout_sticky: got %b, expected 1", timeout_err); end
    enable = 1'b1;
    @(negedge clk);
    nvec++;
    if (timeout_err !== 1'b0 || tdc_start !== 1'b1) begin
      nerr++; $display("FAIL err_restart: err=%b start=%b, expected 0/1", timeout_err, tdc_start);
    end
    smp[0] = 40; smp[1] = 50; smp[2] = 60; smp[3] = 70;
    run_burst("after_err", 2, 1'b0, 1'b0);
  endtask

  task automatic test_rst_mid;
    int t;
    enable = 1'b1;
    t = 0;
    while (tdc_start !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    nvec++;
    if (tdc_start !== 1'b0 || busy !== 1'b0) begin
      nerr++; $display("FAIL rst_start: start=%b busy=%b, expected 0/0", tdc_start, busy);
    end
    rst = 1'b0; enable = 1'b0;
    @(negedge clk);
    enable = 1'b1; en_after = 1'b0; hold_ready = 1'b0;
    convert(8'd200, 1'b0, 1'b0);
    convert(8'd201, 1'b0, 1'b0);
    convert(8'd0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    nvec++;
    if ({tdc_start, busy, avg_valid, timeout_err} !== 4'b0 || avg_out !== '0) begin
      nerr++; $display("FAIL rst_wait: flags=%b avg=%0d, expected 0000/0",
                       {tdc_start, busy, avg_valid, timeout_err}, avg_out);
    end
    rst = 1'b0;
    foreach (smp[i]) smp[i] = 8'd1;
    run_burst("rst_recover", 1, 1'b0, 1'b0);
  endtask

  task automatic test_stale;
    tdc_ready = 1'b1;
    @(negedge clk);
    smp[0] = 17; smp[1] = 99; smp[2] = 0; smp[3] = 250;
    run_burst("stale", 3, 1'b0, 1'b1);
    tdc_ready = 1'b0; hold_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    for (int b = 0; b < 4; b++) begin
      foreach (smp[i]) smp[i] = WIDTH'($urandom);
      run_burst("random", int'($urandom_range(0, 5)), 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_back_to_back();
    test_timeout();
    test_rst_mid();
    test_stale();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
